// File: rtl/alu_result_demux.sv
// 1-to-16 result distributor: buffers one ALU result, writes it into a slot.
// Optional DEMUX_OVERWRITE_EN: never stall, flag overwritten slots on OVF.
module alu_result_demux #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N-1:0]    DIN,
  input  logic [3:0]      SEL,
  input  logic            IN_VALID,
  output logic            IN_READY,
  output logic [16*N-1:0] Q,
  output logic [15:0]     Q_VALID,
  input  logic [15:0]     Q_ACK,
  output logic            OVF,
  output logic [CW-1:0]   DCOUNT
);

  typedef enum logic {
    EMPTY,
    HELD
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic [N-1:0]    hd;
  logic [3:0]      hs;
  logic [16*N-1:0] q_r;
  logic [15:0]     qv_r;
  logic [CW-1:0]   cnt;
  logic            free;
  logic            wr;
  logic [15:0]     wr_mask;

`ifdef DEMUX_OVERWRITE_EN
  logic ovf_r;
  assign free = 1'b1;
  assign OVF  = ovf_r;
`else
  assign free = ~qv_r[hs] | Q_ACK[hs];
  assign OVF  = 1'b0;
`endif

  assign IN_READY = (state == EMPTY);
  assign Q        = q_r;
  assign Q_VALID  = qv_r;
  assign DCOUNT   = cnt;

  always_comb begin
    state_nx = state;
    wr       = 1'b0;
    unique case (state)
      EMPTY: if (IN_VALID) state_nx = HELD;
      HELD: begin
        if (free) begin
          wr       = 1'b1;
          state_nx = EMPTY;
        end
      end
      default: state_nx = EMPTY;
    endcase
    wr_mask = wr ? (16'h0001 << hs) : 16'h0000;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= EMPTY;
      hd    <= '0;
      hs    <= '0;
      q_r   <= '0;
      qv_r  <= '0;
      cnt   <= '0;
`ifdef DEMUX_OVERWRITE_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      if (state == EMPTY && IN_VALID) begin
        hd <= DIN;
        hs <= SEL;
      end
      for (int j = 0; j < 16; j++) begin
        if (wr_mask[j]) q_r[j*N +: N] <= hd;
      end
      // a write to slot j wins over an ack of slot j on the same edge
      qv_r <= (qv_r & ~Q_ACK) | wr_mask;
      cnt  <= cnt + CW'(wr);
`ifdef DEMUX_OVERWRITE_EN
      if (wr && qv_r[hs] && !Q_ACK[hs]) ovf_r <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_alu_result_demux.sv
// Directed bench for alu_result_demux; a CW=4 twin checks counter wrap.
// Expectations follow DEMUX_OVERWRITE_EN when the bench is built with it.
module tb_alu_result_demux;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [7:0]   DIN = '0;
  logic [3:0]   SEL = '0;
  logic         IN_VALID = 1'b0;
  logic [15:0]  Q_ACK = '0;
  logic         IN_READY, IN_READY_w;
  logic [127:0] Q, Q_w;
  logic [15:0]  Q_VALID, Q_VALID_w;
  logic         OVF, OVF_w;
  logic [15:0]  DCOUNT;
  logic [3:0]   DCOUNT_w;

  int checks   = 0;
  int failures = 0;
  logic [127:0] exp_q;
  logic         ovf_exp;

  always #5 CLK = ~CLK;

  alu_result_demux #(.N(8), .CW(16)) u_dut (
    .CLK(CLK), .RST(RST), .DIN(DIN), .SEL(SEL),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .Q(Q), .Q_VALID(Q_VALID), .Q_ACK(Q_ACK),
    .OVF(OVF), .DCOUNT(DCOUNT)
  );

  alu_result_demux #(.N(8), .CW(4)) u_wrap (
    .CLK(CLK), .RST(RST), .DIN(DIN), .SEL(SEL),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY_w),
    .Q(Q_w), .Q_VALID(Q_VALID_w), .Q_ACK(Q_ACK),
    .OVF(OVF_w), .DCOUNT(DCOUNT_w)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] slot(input int k);
    return Q[k*8 +: 8];
  endfunction

  task automatic send(input logic [7:0] d, input logic [3:0] s);
    DIN = d;
    SEL = s;
    IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
  endtask

  initial begin
    step();
    step();
    RST = 1'b0;
    chk("rst_ready", IN_READY, 1);
    chk("rst_qvalid", Q_VALID, 0);
    chk("rst_q", Q, 0);
    chk("rst_dcount", DCOUNT, 0);
    chk("rst_ovf", OVF, 0);

    DIN = 8'hA5; SEL = 4'd3; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    chk("cap_ready", IN_READY, 0);
    chk("cap_qvalid", Q_VALID, 0);
    step();
    chk("wr_q3", slot(3), 8'hA5);
    chk("wr_qvalid", Q_VALID, 16'h0008);
    chk("wr_dcount", DCOUNT, 1);
    chk("wr_ready", IN_READY, 1);

    DIN = 8'h3C; SEL = 4'd3; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
`ifdef DEMUX_OVERWRITE_EN
    ovf_exp = 1'b1;
    chk("ow_q3", slot(3), 8'h3C);
    chk("ow_ready", IN_READY, 1);
    chk("ow_ovf", OVF, 1);
    chk("ow_dcount", DCOUNT, 2);
`else
    ovf_exp = 1'b0;
    step();
    step();
    chk("bp_ready", IN_READY, 0);
    chk("bp_q3", slot(3), 8'hA5);
    chk("bp_dcount", DCOUNT, 1);
    chk("bp_ovf", OVF, 0);
    Q_ACK = 16'h0008;
    step();
    Q_ACK = '0;
    chk("ackwr_q3", slot(3), 8'h3C);
    chk("ackwr_dcount", DCOUNT, 2);
    chk("ackwr_ready", IN_READY, 1);
`endif
    chk("post3_qvalid", Q_VALID, 16'h0008);

    Q_ACK = 16'h0008;
    step();
    chk("ack_clear", Q_VALID, 16'h0000);
    Q_ACK = 16'hFFFF;
    step();
    Q_ACK = '0;
    chk("ack_empty_qv", Q_VALID, 16'h0000);
    chk("ack_keep_q3", slot(3), 8'h3C);
    chk("ovf_sticky", OVF, ovf_exp);

    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_q = '0;
    for (int s = 0; s < 16; s++) begin
      send(8'(s * 8'h11), 4'(s));
      exp_q[s*8 +: 8] = 8'(s * 8'h11);
    end
    chk("fill_qvalid", Q_VALID, 16'hFFFF);
    chk("fill_q", Q, exp_q);
    chk("fill_q15", slot(15), 8'hFF);
    chk("fill_dcount", DCOUNT, 16);
    chk("fill_dcount4", DCOUNT_w, 0);
    Q_ACK = 16'h00FF;
    step();
    Q_ACK = '0;
    chk("ack_multi", Q_VALID, 16'hFF00);

    send(8'h5A, 4'd0);
    chk("wrap_dcount4", DCOUNT_w, 1);
    chk("wrap_dcount", DCOUNT, 17);
    chk("wrap_q0", slot(0), 8'h5A);

    DIN = 8'h77; SEL = 4'd9; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("mid_qvalid", Q_VALID, 0);
    chk("mid_q9", slot(9), 0);
    chk("mid_dcount", DCOUNT, 0);
    chk("mid_ready", IN_READY, 1);
    step();
    chk("mid_discard_qv", Q_VALID, 0);
    chk("mid_discard_cnt", DCOUNT, 0);
    chk("mid_ovf", OVF, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
